apb_ram_ws: RTL
===============

Name: apb_ram_ws

Overview:
Parametrised APB4 completer RAM; next generation of the team's APB RAM slave. Adds:
- configurable depth
- byte-lane write strobes (PSTRB)
- fixed programmable wait states
- alignment and range error checking
- hardware memory-clear sweep after reset

Sits behind the APB interconnect as a scratch/config store and as the reference target for APB requester verification.

Parameters:
ADDR_WIDTH, 32, width of PADDR in bits.
DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16, 32 or 64.
DEPTH, 64, number of DATA_WIDTH words; need not be a power of two.
WAIT_STATES, 0, number of PREADY-low access cycles inserted before completion (0..15).
CLEAR_ON_RESET, 1, when 1, sweep every word to zero after reset, one word per cycle.

Ports:
PCLK  input  1  clock; all logic on rising edge.
PRESET  input  1  synchronous, active-high reset.
PADDR  input  ADDR_WIDTH  byte address.
PSEL  input  1  completer select.
PENABLE  input  1  access phase indicator.
PWRITE  input  1  1 = write, 0 = read.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  DATA_WIDTH/8  byte-lane write enables.
PRDATA  output  DATA_WIDTH  read data; valid when PREADY=1 and PWRITE=0.
PREADY  output  1  transfer completion (registered).
PSLVERR  output  1  transfer error; valid only while PREADY=1.
init_busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (PRESET=1 at an edge) forces outputs low: PRDATA=0, PREADY=0, PSLVERR=0.
- Reset sets init_busy=1 if CLEAR_ON_RESET, else 0. The init counter goes to 0.
- Reset mid-transfer aborts the transfer; the write is not committed.
- Memory is not reset directly; it is cleared only by the sweep.
- Word index = PADDR >> log2(DATA_WIDTH/8).

FSM states:
- INIT: entered from reset when CLEAR_ON_RESET=1.
  - Writes 0 to word[cnt] each cycle; cnt increments.
  - After word DEPTH-1, goes to IDLE and deasserts init_busy on the same edge.
  - Sweep takes exactly DEPTH cycles.
  - A setup phase seen during INIT is held: PREADY stays low until INIT ends, then normal wait timing begins.
- IDLE: PREADY=0.
  - On PSEL=1 and PENABLE=0 (setup phase), capture address, direction, data, strobes and error flags.
  - If WAIT_STATES=0, go to DONE; else load wait counter with WAIT_STATES and go to WAIT.
- WAIT: counter decrements each cycle while PSEL=1 and PENABLE=1. Goes to DONE on the edge where the counter reaches 0.
- DONE: PREADY=1 for exactly one cycle.
  - Write with no error: commit PWDATA lanes where PSTRB[i]=1 on this edge.
  - Read: PRDATA shows the word.
  - Next state is IDLE, so back-to-back transfers re-enter IDLE and see the next setup.

Timing:
- Total latency from setup phase to PREADY=1 = WAIT_STATES+1 cycles.
- With WAIT_STATES=0 this is a zero-wait APB transfer.

Errors (evaluated at capture, PSLVERR=1 with PREADY):
- Address misaligned (low log2(DATA_WIDTH/8) bits non-zero).
- Word index >= DEPTH.
- On error: no memory write, PRDATA=0.
- PSTRB=0 on a write is legal: no lanes change, PSLVERR=0.

Other rules:
- PRDATA returns to 0 on the cycle after DONE. PSLVERR clears with PREADY.
- PSEL dropping during WAIT or DONE is a requester protocol violation. The FSM returns to IDLE with no commit and PREADY=0.
- Read-after-write to the same address in consecutive transfers returns the new data.

Decomposition:
- Package apb_ram_pkg:
  - state enum (INIT, IDLE, WAIT, DONE)
  - function returning log2 of byte lanes
  - error-cause enum (NONE, MISALIGN, RANGE), used for coverage only
- Sub-module apb_ram_mem: single-port synchronous-write, asynchronous-read word array with per-byte write enables, parametrised by DATA_WIDTH and DEPTH. The sweep and APB writes share its one write port; they are exclusive by state.

Test Plan:
- Reset with DEPTH=64, CLEAR_ON_RESET=1 -> init_busy high exactly 64 cycles; then read of 0x00 and 0xFC both return 0x00000000, PSLVERR=0.
- WAIT_STATES=3: write 0xDEADBEEF to 0x10, PSTRB=4'hF -> PREADY high on the 4th cycle after setup, exactly one cycle. Read 0x10 -> 0xDEADBEEF.
- Write 0x11223344 to 0x20 PSTRB=4'hF, then write 0xAABBCCDD with PSTRB=4'b0101 -> read 0x20 returns 0x11BB33DD.
- Read 0x102 (misaligned) and 0x100 (word 64, DEPTH=64) -> PREADY=1, PSLVERR=1, PRDATA=0. A write to 0x100 leaves memory unchanged.
- Setup phase issued 2 cycles after reset release with DEPTH=64, WAIT_STATES=0 -> PREADY stays low until init_busy falls, then rises 1 cycle later. Data is correct.
- PRESET asserted during WAIT of a write to 0x08 -> no commit; after the sweep, read 0x08 = 0. PSEL dropped during WAIT -> FSM returns to IDLE, PREADY never asserted.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the wait-state APB RAM completer.
package apb_ram_pkg;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StDone
    } state_e;

    // Captured error cause; kept distinct so coverage can tell the two apart.
    typedef enum logic [1:0] {
        ErrNone,
        ErrMisalign,
        ErrRange
    } err_e;

    function automatic int unsigned lane_bits(int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// Word array with one synchronous byte-masked write port and an asynchronous read port.
module apb_ram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IdxW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IdxW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_ram_ws.sv
// APB4 completer RAM with byte strobes, fixed wait states, error checks and a post-reset clear sweep.
module apb_ram_ws
    import apb_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    init_busy
);

    localparam int unsigned Lanes    = DATA_WIDTH / 8;
    localparam int unsigned LaneBits = lane_bits(DATA_WIDTH);
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'((64'd1 << LaneBits) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DepthA    = ADDR_WIDTH'(DEPTH);
    localparam logic [IdxW-1:0]       LastIdx   = IdxW'(DEPTH - 1);
    localparam logic [3:0]            WaitLoad  = 4'(WAIT_STATES);
    localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StInit : StIdle;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       cnt_q, cnt_d;
    logic [3:0]            wait_q, wait_d;
    logic                  pend_q, pend_d;
    logic                  pready_q, pready_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [Lanes-1:0]      strb_q, strb_d;
    err_e                  cause_q, cause_d;

    logic                  setup, access;
    logic [ADDR_WIDTH-1:0] word_addr;
    err_e                  cause_in;

    logic                  mem_we;
    logic [IdxW-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    logic [Lanes-1:0]      mem_wstrb;

    assign setup     = PSEL & ~PENABLE;
    assign access    = PSEL & PENABLE;
    assign word_addr = PADDR >> LaneBits;

    always_comb begin
        cause_in = ErrNone;
        if ((PADDR & AlignMask) != '0) begin
            cause_in = ErrMisalign;
        end else if (word_addr >= DepthA) begin
            cause_in = ErrRange;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        pend_d    = pend_q;
        pready_d  = 1'b0;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        cause_d   = cause_q;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = wdata_q;
        mem_wstrb = strb_q;

        if ((state_q == StInit || state_q == StIdle) && setup) begin
            idx_d   = IdxW'(word_addr);
            write_d = PWRITE;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
            cause_d = cause_in;
        end

        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                mem_wstrb = '1;
                // A setup arriving mid-sweep is remembered and started once IDLE is reached.
                if (setup) pend_d = 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (pend_q || setup) begin
                    pend_d = 1'b0;
                    if (WaitLoad == 4'd0) begin
                        state_d  = StDone;
                        pready_d = 1'b1;
                    end else begin
                        wait_d  = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (PENABLE) begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == 4'd1) begin
                        state_d  = StDone;
                        pready_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (access && write_q && cause_q == ErrNone) mem_we = 1'b1;
            end
            default: state_d = ResetState;
        endcase

        if (PRESET) mem_we = 1'b0;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ResetState;
            cnt_q    <= '0;
            wait_q   <= '0;
            pend_q   <= 1'b0;
            pready_q <= 1'b0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            cause_q  <= ErrNone;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            pend_q   <= pend_d;
            pready_q <= pready_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            cause_q  <= cause_d;
        end
    end

    apb_ram_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk_i  (PCLK),
        .we_i   (mem_we),
        .waddr_i(mem_waddr),
        .wdata_i(mem_wdata),
        .wstrb_i(mem_wstrb),
        .raddr_i(idx_q),
        .rdata_o(mem_rdata)
    );

    assign init_busy = (state_q == StInit);
    assign PREADY    = pready_q;
    assign PSLVERR   = pready_q & (cause_q != ErrNone);
    assign PRDATA    = (pready_q && !write_q && cause_q == ErrNone) ? mem_rdata : '0;

endmodule
